// File: rtl/seq_controller.sv
// seq_controller: multi-cycle instruction sequencer.
// Fetches instructions over a req/ack handshake, decodes the IR fields and
// drives register-file / data-memory / ALU control strobes.
module seq_controller #(
  parameter int WIDTH    = 16,
  parameter int I_ADDR_W = 8,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  output logic                imem_req,
  output logic [I_ADDR_W-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [WIDTH-1:0]    imem_data,
  input  logic                alu_zero,
  output logic                D_wr,
  output logic                RF_s,
  output logic                RF_W_en,
  output logic [D_ADDR_W-1:0] D_addr,
  output logic [R_ADDR_W-1:0] RF_W_addr,
  output logic [R_ADDR_W-1:0] RF_A_addr,
  output logic [R_ADDR_W-1:0] RF_B_addr,
  output logic [3:0]          ALU_sel,
  output logic [WIDTH-1:0]    IR_Out,
  output logic [I_ADDR_W-1:0] PC_Out,
  output logic                halted
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_LOAD2  = 3'd3,
    S_HALT   = 3'd4
  } state_t;

  localparam logic [3:0] OP_LOAD   = 4'h1;
  localparam logic [3:0] OP_STORE  = 4'h2;
  localparam logic [3:0] OP_ALU_LO = 4'h3;
  localparam logic [3:0] OP_ALU_HI = 4'hC;
  localparam logic [3:0] OP_JMP    = 4'hD;
  localparam logic [3:0] OP_BRZ    = 4'hE;
  localparam logic [3:0] OP_HALT   = 4'hF;

  localparam logic [I_ADDR_W-1:0] PC_INC = {{(I_ADDR_W-1){1'b0}}, 1'b1};

  state_t              state;
  state_t              next_state;
  logic [WIDTH-1:0]    ir;
  logic [I_ADDR_W-1:0] pc;
  logic [3:0]          op;
  logic [I_ADDR_W-1:0] target;
  logic                is_alu;
  logic                take_jump;

  // IR field decode; all fields are plain slices of the held instruction
  assign op        = ir[WIDTH-1 -: 4];
  assign RF_W_addr = ir[WIDTH-5 -: R_ADDR_W];
  assign RF_A_addr = ir[WIDTH-5-R_ADDR_W -: R_ADDR_W];
  assign RF_B_addr = ir[R_ADDR_W-1:0];
  assign D_addr    = ir[D_ADDR_W-1:0];
  assign target    = ir[I_ADDR_W-1:0];
  assign ALU_sel   = op;
  assign is_alu    = (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  assign take_jump = (op == OP_JMP) || ((op == OP_BRZ) && alu_zero);

  assign imem_addr = pc;
  assign IR_Out    = ir;
  assign PC_Out    = pc;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= next_state;
  end

  // Next-state logic; an ack only counts while in FETCH, where req is high
  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:  if (imem_ack) next_state = S_DECODE;
      S_DECODE: next_state = S_EXEC;
      S_EXEC: begin
        case (op)
          OP_LOAD: next_state = S_LOAD2;
          OP_HALT: next_state = S_HALT;
          default: next_state = S_FETCH;
        endcase
      end
      S_LOAD2:  next_state = S_FETCH;
      S_HALT:   if (run) next_state = S_FETCH;
      default:  next_state = S_FETCH;
    endcase
  end

  // PC/IR: capture on fetch ack, redirect PC on a taken JMP/BRZ in EXEC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
      ir <= '0;
    end else if ((state == S_FETCH) && imem_ack) begin
      ir <= imem_data;
      pc <= pc + PC_INC;
    end else if ((state == S_EXEC) && take_jump) begin
      pc <= target;
    end
  end

  // Control strobes; imem_req is gated by reset so it drops with no clock edge
  always_comb begin
    imem_req = 1'b0;
    D_wr     = 1'b0;
    RF_s     = 1'b0;
    RF_W_en  = 1'b0;
    halted   = 1'b0;
    case (state)
      S_FETCH: imem_req = reset;
      S_EXEC: begin
        if (is_alu) RF_W_en = 1'b1;
        if (op == OP_LOAD) RF_s = 1'b1;
        if (op == OP_STORE) D_wr = 1'b1;
      end
      S_LOAD2: begin
        RF_s    = 1'b1;
        RF_W_en = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_seq_controller.sv
// tb_seq_controller: directed and randomized checks of seq_controller
// against a small instruction-level reference model.
module tb_seq_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic        alu_zero;
  logic        D_wr;
  logic        RF_s;
  logic        RF_W_en;
  logic [7:0]  D_addr;
  logic [3:0]  RF_W_addr;
  logic [3:0]  RF_A_addr;
  logic [3:0]  RF_B_addr;
  logic [3:0]  ALU_sel;
  logic [15:0] IR_Out;
  logic [7:0]  PC_Out;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  seq_controller #(.WIDTH(16), .I_ADDR_W(8), .D_ADDR_W(8), .R_ADDR_W(4)) dut (
    .clk(clk), .reset(reset), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .alu_zero(alu_zero), .D_wr(D_wr), .RF_s(RF_s), .RF_W_en(RF_W_en), .D_addr(D_addr),
    .RF_W_addr(RF_W_addr), .RF_A_addr(RF_A_addr), .RF_B_addr(RF_B_addr), .ALU_sel(ALU_sel),
    .IR_Out(IR_Out), .PC_Out(PC_Out), .halted(halted)
  );

  always #5 clk = ~clk;

  // Model: address of the next fetch after executing instr fetched at pc_now
  function automatic logic [7:0] model_next_pc(input logic [7:0] pc_now, input logic [15:0] instr, input logic z);
    int op;
    int tgt;
    int nxt;
    op  = int'(instr) / 4096;
    tgt = int'(instr) % 256;
    nxt = (int'(pc_now) + 1) % 256;
    if (op == 13 || (op == 14 && z)) return tgt[7:0];
    return nxt[7:0];
  endfunction

  // Model: strobes {RF_W_en, RF_s, D_wr} in EXEC for a given opcode
  function automatic logic [2:0] model_exec_strobes(input int op);
    logic [2:0] s;
    s = 3'b000;
    if (op >= 3 && op <= 12) s[2] = 1'b1;
    if (op == 1) s[1] = 1'b1;
    if (op == 2) s[0] = 1'b1;
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    imem_ack = 1'b0;
    run      = 1'b0;
    alu_zero = 1'b0;
    #2;
    reset = 1'b1;
    tick();
  endtask

  // Waits (bounded) for a request, stalls wait_cycles, then acks with instr
  task automatic serve_fetch(input logic [15:0] instr, input int wait_cycles,
                             output logic [7:0] addr, output bit ok);
    ok   = 1'b0;
    addr = '0;
    for (int i = 0; i < 20 && imem_req !== 1'b1; i++) tick();
    if (imem_req === 1'b1) begin
      for (int w = 0; w < wait_cycles; w++) tick();
      addr      = imem_addr;
      imem_data = instr;
      imem_ack  = 1'b1;
      tick();
      imem_ack  = 1'b0;
      imem_data = 16'($urandom);
      ok        = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; run = 1'b0; imem_ack = 1'b0; imem_data = '0; alu_zero = 1'b0;
    #3;
    n_checks++;
    if ({imem_req, D_wr, RF_W_en, RF_s, halted} !== 5'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000", {imem_req, D_wr, RF_W_en, RF_s, halted});
    end
    n_checks++;
    if (PC_Out !== 8'h00 || IR_Out !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL reset_pc_ir: got pc=%h ir=%h expected 00/0000", PC_Out, IR_Out);
    end
    reset = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL reset_first_req: got req=%b addr=%h expected 1/00", imem_req, imem_addr);
    end
  endtask

  task automatic test_alu_zero_wait();
    logic [7:0] a;
    bit ok;
    do_reset();
    serve_fetch(16'h3123, 0, a, ok);
    n_checks++;
    if (!ok || a !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL alu_fetch_addr: got %h ok=%0d expected 00", a, ok);
    end
    n_checks++;
    if ({RF_W_en, D_wr, imem_req} !== 3'b000 || PC_Out !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL alu_decode: got we/wr/req=%b pc=%h expected 000/01", {RF_W_en, D_wr, imem_req}, PC_Out);
    end
    tick();
    n_checks++;
    if (RF_W_en !== 1'b1 || RF_s !== 1'b0 || ALU_sel !== 4'h3) begin
      n_fail++;
      $display("[TB] FAIL alu_exec_ctrl: got we=%b s=%b sel=%h expected 1/0/3", RF_W_en, RF_s, ALU_sel);
    end
    n_checks++;
    if ({RF_W_addr, RF_A_addr, RF_B_addr} !== 12'h123 || PC_Out !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL alu_exec_fields: got %h pc=%h expected 123/01", {RF_W_addr, RF_A_addr, RF_B_addr}, PC_Out);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01 || RF_W_en !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL alu_next_fetch: got req=%b addr=%h we=%b expected 1/01/0", imem_req, imem_addr, RF_W_en);
    end
  endtask

  task automatic test_load_delayed();
    logic [7:0] a;
    bit ok;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== 8'h00) begin
        n_fail++;
        $display("[TB] FAIL load_wait_req: cycle %0d got req=%b addr=%h expected 1/00", c, imem_req, imem_addr);
      end
      tick();
    end
    serve_fetch(16'h1A05, 0, a, ok);
    n_checks++;
    if (!ok || IR_Out !== 16'h1A05 || {RF_W_en, RF_s, D_wr} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL load_decode: got ir=%h strobes=%b expected 1a05/000", IR_Out, {RF_W_en, RF_s, D_wr});
    end
    tick();
    n_checks++;
    if (D_addr !== 8'h05 || {RF_W_en, RF_s, D_wr} !== 3'b010) begin
      n_fail++;
      $display("[TB] FAIL load_exec: got daddr=%h strobes=%b expected 05/010", D_addr, {RF_W_en, RF_s, D_wr});
    end
    tick();
    n_checks++;
    if (D_addr !== 8'h05 || {RF_W_en, RF_s, D_wr} !== 3'b110 || imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL load_load2: got daddr=%h strobes=%b req=%b expected 05/110/0", D_addr, {RF_W_en, RF_s, D_wr}, imem_req);
    end
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h01 || {RF_W_en, RF_s} !== 2'b00) begin
      n_fail++;
      $display("[TB] FAIL load_next_fetch: got req=%b addr=%h we/s=%b expected 1/01/00", imem_req, imem_addr, {RF_W_en, RF_s});
    end
  endtask

  task automatic test_branch();
    logic [7:0] a;
    bit ok;
    do_reset();
    alu_zero = 1'b1;
    serve_fetch(16'hE040, 0, a, ok);
    tick();
    tick();
    n_checks++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 8'h40) begin
      n_fail++;
      $display("[TB] FAIL brz_taken: got req=%b addr=%h expected 1/40", imem_req, imem_addr);
    end
    alu_zero = 1'b0;
    serve_fetch(16'hE040, 1, a, ok);
    tick();
    tick();
    n_checks++;
    if (!ok || imem_req !== 1'b1 || imem_addr !== 8'h41) begin
      n_fail++;
      $display("[TB] FAIL brz_not_taken: got req=%b addr=%h expected 1/41", imem_req, imem_addr);
    end
  endtask

  task automatic test_wrap_jmp();
    logic [7:0] a;
    bit ok;
    do_reset();
    serve_fetch(16'hD0FF, 0, a, ok);
    tick();
    tick();
    serve_fetch(16'h0000, 0, a, ok);
    n_checks++;
    if (!ok || a !== 8'hFF || PC_Out !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL pc_wrap: got fetch=%h pc=%h expected ff/00", a, PC_Out);
    end
    tick();
    n_checks++;
    if ({RF_W_en, RF_s, D_wr} !== 3'b000) begin
      n_fail++;
      $display("[TB] FAIL nop_strobes: got %b expected 000", {RF_W_en, RF_s, D_wr});
    end
    tick();
    serve_fetch(16'hD0AA, 0, a, ok);
    n_checks++;
    if (!ok || a !== 8'h00) begin
      n_fail++;
      $display("[TB] FAIL jmp_fetch_addr: got %h expected 00", a);
    end
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'hAA) begin
      n_fail++;
      $display("[TB] FAIL jmp_target: got req=%b addr=%h expected 1/aa", imem_req, imem_addr);
    end
  endtask

  task automatic test_halt();
    logic [7:0] a;
    bit ok;
    bit bad;
    do_reset();
    serve_fetch(16'hF000, 0, a, ok);
    tick();
    n_checks++;
    if (!ok || halted !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL halt_exec: got halted=%b expected 0", halted);
    end
    tick();
    bad = 1'b0;
    for (int c = 0; c < 10; c++) begin
      imem_ack = c[0];
      if (halted !== 1'b1 || imem_req !== 1'b0 || PC_Out !== 8'h01) bad = 1'b1;
      tick();
    end
    n_checks++;
    if (bad || halted !== 1'b1 || imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL halt_hold: got halted=%b req=%b pc=%h expected 1/0/01", halted, imem_req, PC_Out);
    end
    imem_ack = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    n_checks++;
    if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 8'h01) begin
      n_fail++;
      $display("[TB] FAIL halt_resume: got halted=%b req=%b addr=%h expected 0/1/01", halted, imem_req, imem_addr);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] a;
    bit ok;
    do_reset();
    serve_fetch(16'hD030, 0, a, ok);
    tick();
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h30) begin
      n_fail++;
      $display("[TB] FAIL rst_fetch_setup: got req=%b addr=%h expected 1/30", imem_req, imem_addr);
    end
    #2;
    reset = 1'b0;
    imem_ack = 1'b1;
    imem_data = 16'h3123;
    #1;
    n_checks++;
    if (imem_req !== 1'b0 || PC_Out !== 8'h00 || IR_Out !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_fetch: got req=%b pc=%h ir=%h expected 0/00/0000", imem_req, PC_Out, IR_Out);
    end
    @(negedge clk);
    imem_ack = 1'b0;
    reset = 1'b1;
    tick();
    n_checks++;
    if (imem_req !== 1'b1 || imem_addr !== 8'h00 || IR_Out !== 16'h0000) begin
      n_fail++;
      $display("[TB] FAIL rst_ack_discard: got req=%b addr=%h ir=%h expected 1/00/0000", imem_req, imem_addr, IR_Out);
    end
    serve_fetch(16'hD040, 0, a, ok);
    tick();
    tick();
    serve_fetch(16'h2011, 0, a, ok);
    tick();
    n_checks++;
    if (!ok || D_wr !== 1'b1 || RF_W_en !== 1'b0 || D_addr !== 8'h11) begin
      n_fail++;
      $display("[TB] FAIL store_exec: got wr=%b we=%b daddr=%h expected 1/0/11", D_wr, RF_W_en, D_addr);
    end
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if (D_wr !== 1'b0 || PC_Out !== 8'h00 || RF_W_en !== 1'b0 || imem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL rst_mid_store: got wr=%b pc=%h we=%b req=%b expected 0/00/0/0", D_wr, PC_Out, RF_W_en, imem_req);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_random();
    logic [7:0]  pc_m;
    logic [7:0]  a;
    logic [7:0]  exp_pc;
    logic [15:0] instr;
    logic [2:0]  exp_s;
    bit          ok;
    int          op;
    int          z;
    do_reset();
    pc_m = 8'h00;
    for (int k = 0; k < 40; k++) begin
      op    = int'($urandom_range(0, 14));
      instr = 16'(op * 4096 + int'($urandom_range(0, 4095)));
      z     = int'($urandom_range(0, 1));
      alu_zero = z[0];
      serve_fetch(instr, int'($urandom_range(0, 3)), a, ok);
      n_checks++;
      if (!ok || a !== pc_m) begin
        n_fail++;
        $display("[TB] FAIL rnd_fetch_addr[%0d]: got %h ok=%0d expected %h", k, a, ok, pc_m);
        break;
      end
      exp_pc = 8'((int'(pc_m) + 1) % 256);
      n_checks++;
      if (IR_Out !== instr || PC_Out !== exp_pc || {RF_W_en, D_wr, imem_req} !== 3'b000) begin
        n_fail++;
        $display("[TB] FAIL rnd_decode[%0d]: got ir=%h pc=%h strb=%b expected %h/%h/000",
                 k, IR_Out, PC_Out, {RF_W_en, D_wr, imem_req}, instr, exp_pc);
      end
      tick();
      exp_s = model_exec_strobes(op);
      n_checks++;
      if ({RF_W_en, RF_s, D_wr} !== exp_s || ALU_sel !== op[3:0] || D_addr !== instr[7:0] || imem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL rnd_exec[%0d]: got strb=%b sel=%h daddr=%h req=%b expected %b/%h/%h/0",
                 k, {RF_W_en, RF_s, D_wr}, ALU_sel, D_addr, imem_req, exp_s, op[3:0], instr[7:0]);
      end
      tick();
      if (op == 1) begin
        n_checks++;
        if ({RF_W_en, RF_s, D_wr} !== 3'b110 || D_addr !== instr[7:0]) begin
          n_fail++;
          $display("[TB] FAIL rnd_load2[%0d]: got strb=%b daddr=%h expected 110/%h",
                   k, {RF_W_en, RF_s, D_wr}, D_addr, instr[7:0]);
        end
        tick();
      end
      pc_m = model_next_pc(pc_m, instr, z[0]);
      n_checks++;
      if (imem_req !== 1'b1 || imem_addr !== pc_m) begin
        n_fail++;
        $display("[TB] FAIL rnd_latency[%0d]: got req=%b addr=%h expected 1/%h", k, imem_req, imem_addr, pc_m);
      end
    end
  endtask

  // Global time bound so a stuck run still ends
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Test sequence
  initial begin
    test_reset();
    test_alu_zero_wait();
    test_load_delayed();
    test_branch();
    test_wrap_jmp();
    test_halt();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_controller.md
SEQ_CONTROLLER -- requirements
Module: seq_controller

Interface
REQ-001 SHALL have parameter WIDTH, default 16, instruction/IR width.
REQ-002 SHALL have parameter I_ADDR_W, default 8, instruction address width.
REQ-003 SHALL have parameter D_ADDR_W, default 8, data memory address width.
REQ-004 SHALL have parameter R_ADDR_W, default 4, register file address width; WIDTH >= 4+3*R_ADDR_W and D_ADDR_W <= WIDTH-4-R_ADDR_W required.
REQ-005 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-006 SHALL have port reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port run  in  1  level; leaves HALT when high.
REQ-008 SHALL have ports imem_req out 1, imem_addr out I_ADDR_W, imem_ack in 1, imem_data in WIDTH  instruction memory request/ack handshake.
REQ-009 SHALL have port alu_zero  in  1  ALU zero flag, sampled in EXEC.
REQ-010 SHALL have ports D_wr, RF_s, RF_W_en  out  1 each  data write, RF write-source select (1=memory), RF write enable.
REQ-011 SHALL have ports D_addr out D_ADDR_W; RF_W_addr, RF_A_addr, RF_B_addr out R_ADDR_W; ALU_sel out 4.
REQ-012 SHALL have ports IR_Out out WIDTH, PC_Out out I_ADDR_W, halted out 1.

Function
REQ-013 SHALL decode fields: op=IR[WIDTH-1 -: 4]; RF_W_addr=next R_ADDR_W bits; RF_A_addr=next R_ADDR_W bits; RF_B_addr=low R_ADDR_W bits; D_addr=low D_ADDR_W bits; jump target=low I_ADDR_W bits.
REQ-014 SHALL implement opcodes: 0000 NOP, 0001 LOAD, 0010 STORE, 0011-1100 ALU (ALU_sel=op), 1101 JMP, 1110 BRZ, 1111 HALT.
REQ-015 SHALL implement FSM states FETCH, DECODE, EXEC, LOAD2, HALT; reset state FETCH.
REQ-016 FETCH SHALL assert imem_req with imem_addr=PC held stable until the cycle imem_ack=1; on that edge IR<=imem_data, PC<=PC+1 (wraps 2^I_ADDR_W-1 -> 0), state->DECODE.
REQ-017 imem_ack while imem_req=0 SHALL be ignored; an ack may arrive the same cycle as req (zero wait).
REQ-018 DECODE SHALL last exactly one cycle with all write strobes low, then ->EXEC.
REQ-019 EXEC ALU op SHALL assert RF_W_en=1, RF_s=0 for one cycle, then ->FETCH.
REQ-020 EXEC LOAD SHALL assert RF_s=1, RF_W_en=0; LOAD2 SHALL assert RF_s=1, RF_W_en=1; D_addr valid both cycles; then ->FETCH.
REQ-021 EXEC STORE SHALL assert D_wr=1 for exactly one cycle, then ->FETCH.
REQ-022 EXEC JMP SHALL load PC<=target; BRZ SHALL load PC<=target only if alu_zero=1, else PC unchanged; then ->FETCH.
REQ-023 EXEC NOP SHALL go ->FETCH with no strobes.
REQ-024 EXEC HALT SHALL go ->HALT; halted=1 while in HALT; HALT with run=1 SHALL go ->FETCH next cycle, PC unchanged.
REQ-025 D_wr, RF_W_en, imem_req SHALL be low in every state/op not listed above.
REQ-026 IR_Out SHALL equal IR; PC_Out SHALL equal PC at all times.
REQ-027 Instruction-to-next-fetch latency SHALL be 3 cycles after ack (4 for LOAD).

Reset
REQ-028 reset=0 SHALL immediately and asynchronously set PC=0, IR=0, state=FETCH, D_wr=0, RF_W_en=0, RF_s=0, halted=0.
REQ-029 imem_req SHALL be 0 while reset=0, including reset asserted mid-fetch or mid-LOAD; a pending ack SHALL be discarded.
REQ-030 After reset release, imem_req SHALL assert on the first clock edge with imem_addr=0.

Verification
REQ-031 Reset release, imem returns 0x3123 with zero-wait ack -> DECODE, then EXEC: RF_W_en=1, ALU_sel=3, RF_W_addr=1, RF_A_addr=2, RF_B_addr=3; PC_Out=1.
REQ-032 ack delayed 5 cycles on 0x1A05 -> imem_req/imem_addr=0 stable 5 cycles; then LOAD: D_addr=0x05, RF_s=1 two cycles, RF_W_en=1 only in LOAD2.
REQ-033 0xE040 with alu_zero=1 -> next imem_addr=0x40; same with alu_zero=0 -> next imem_addr=PC+1.
REQ-034 PC=0xFF, fetch NOP -> PC_Out wraps to 0x00; 0xD0AA -> next fetch address 0xAA.
REQ-035 0xF000 -> halted=1, imem_req=0 indefinitely with run=0; run=1 -> FETCH next cycle at unchanged PC.
REQ-036 reset=0 asserted mid-fetch and mid-STORE -> imem_req, D_wr drop without clock edge; PC_Out=0.
